// File: rtl/cpu_bus_pkg.sv
// ---------------------------------------------------------------------------
// cpu_bus_pkg
// Shared definitions for the CPU bus burst initiator:
//   state_e      - initiator FSM states
//   WORD_BYTES   - address increment per bus word
//   WMASK_WRITE  - byte mask driven on write requests
//   WMASK_READ   - byte mask driven on read requests
//   word_align() - clears the byte-offset bits of an address
// ---------------------------------------------------------------------------
package cpu_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_WAIT   = 2'd2,
      ST_FINISH = 2'd3
   } state_e;

   localparam logic [31:0] WORD_BYTES  = 32'd4;
   localparam logic [3:0]  WMASK_WRITE = 4'hF;
   localparam logic [3:0]  WMASK_READ  = 4'h0;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & ~(WORD_BYTES - 32'd1);
   endfunction

endpackage

// File: rtl/cpu_bus_rd_buffer.sv
// ---------------------------------------------------------------------------
// cpu_bus_rd_buffer
// Single-entry output register for the read data stream.
//   clk, reset - clock and synchronous active-high reset
//   load_i     - capture data_i and raise valid_o
//   data_i     - word to capture
//   ready_i    - consumer ready; valid_o clears on valid_o && ready_i
//   valid_o    - registered stream valid
//   data_o     - registered stream data
// ---------------------------------------------------------------------------
module cpu_bus_rd_buffer
   import cpu_bus_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load_i,
   input  logic [31:0] data_i,
   input  logic        ready_i,
   output logic        valid_o,
   output logic [31:0] data_o
);

   logic        valid_q;
   logic [31:0] data_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (load_i) begin
         // The initiator only issues a read once the slot is empty or being
         // drained, so a load never destroys an unconsumed word.
         valid_q <= 1'b1;
         data_q  <= data_i;
      end else if (valid_q && ready_i) begin
         valid_q <= 1'b0;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/cpu_bus_initiator.sv
// ---------------------------------------------------------------------------
// cpu_bus_initiator
// Turns one start command (address, word count, direction) into a burst of
// word-wide CPU bus requests with an auto-incrementing address.
//   clk, reset                     - clock, synchronous active-high reset
//   start, cmd_write, cmd_address,
//   cmd_length                     - command; sampled only when idle
//   busy, done, error              - status; done/error are 1-cycle pulses
//   wr_valid, wr_ready, wr_data    - write data stream (sink)
//   rd_valid, rd_ready, rd_data    - read data stream (source)
//   bus_request, bus_address,
//   bus_wdata, bus_wmask           - bus request side, held until ack
//   bus_ack, bus_rdata             - bus response side
// Optional feature macro: CPU_BUS_INITIATOR_TIMEOUT_EN
//   defined   - a request left unacknowledged for TIMEOUT_CYCLES aborts the
//               burst with error pulsed together with done
//   undefined - WAIT lasts until ack, error is constant 0
// ---------------------------------------------------------------------------
module cpu_bus_initiator
   import cpu_bus_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        cmd_write,
   input  logic [31:0] cmd_address,
   input  logic [15:0] cmd_length,
   output logic        busy,
   output logic        done,
   output logic        error,
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic [31:0] wr_data,
   output logic        rd_valid,
   input  logic        rd_ready,
   output logic [31:0] rd_data,
   output logic        bus_request,
   output logic [31:0] bus_address,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_wmask,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   state_e      state_q;
   logic [31:0] addr_q;
   logic [15:0] remain_q;
   logic        write_q;
   logic        busy_q;
   logic        done_q;
   logic        bus_request_q;
   logic [31:0] bus_address_q;
   logic [31:0] bus_wdata_q;
   logic [3:0]  bus_wmask_q;

   logic        issue_ok;
   logic        rd_load;
   logic        rd_valid_w;

`ifdef CPU_BUS_INITIATOR_TIMEOUT_EN
   // Counter is preloaded with 1 on entry to WAIT, so done lands exactly
   // TIMEOUT_CYCLES cycles after the request pulse.
   localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] wait_cnt_q;
   logic        abort_q;
   logic        error_q;
`else
   // The timeout length has no effect in this build.
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

   // Writes need a data word; reads need room in the output register.
   assign issue_ok = write_q ? wr_valid : (!rd_valid_w || rd_ready);
   assign wr_ready = (state_q == ST_ISSUE) && write_q && wr_valid;
   assign rd_load  = (state_q == ST_WAIT) && bus_ack && !write_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         addr_q        <= '0;
         remain_q      <= '0;
         write_q       <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         bus_request_q <= 1'b0;
         bus_address_q <= '0;
         bus_wdata_q   <= '0;
         bus_wmask_q   <= WMASK_READ;
`ifdef CPU_BUS_INITIATOR_TIMEOUT_EN
         wait_cnt_q    <= '0;
         abort_q       <= 1'b0;
         error_q       <= 1'b0;
`endif
      end else begin
         bus_request_q <= 1'b0;
         done_q        <= 1'b0;
`ifdef CPU_BUS_INITIATOR_TIMEOUT_EN
         error_q       <= 1'b0;
`endif
         unique case (state_q)
            ST_IDLE: begin
               if (start) begin
                  addr_q   <= word_align(cmd_address);
                  remain_q <= cmd_length;
                  write_q  <= cmd_write;
                  busy_q   <= 1'b1;
`ifdef CPU_BUS_INITIATOR_TIMEOUT_EN
                  abort_q  <= 1'b0;
`endif
                  state_q  <= (cmd_length == '0) ? ST_FINISH : ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (issue_ok) begin
                  bus_request_q <= 1'b1;
                  bus_address_q <= addr_q;
                  bus_wmask_q   <= write_q ? WMASK_WRITE : WMASK_READ;
                  if (write_q) begin
                     bus_wdata_q <= wr_data;
                  end
`ifdef CPU_BUS_INITIATOR_TIMEOUT_EN
                  wait_cnt_q    <= 16'd1;
`endif
                  state_q       <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (bus_ack) begin
                  addr_q   <= addr_q + WORD_BYTES;
                  remain_q <= remain_q - 16'd1;
                  state_q  <= (remain_q == 16'd1) ? ST_FINISH : ST_ISSUE;
               end
`ifdef CPU_BUS_INITIATOR_TIMEOUT_EN
               else if (wait_cnt_q >= WAIT_LAST) begin
                  // Abandon the rest of the burst; address stays put.
                  abort_q <= 1'b1;
                  state_q <= ST_FINISH;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 16'd1;
               end
`endif
            end
            ST_FINISH: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
`ifdef CPU_BUS_INITIATOR_TIMEOUT_EN
               error_q <= abort_q;
`endif
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   cpu_bus_rd_buffer u_rd_buffer (
      .clk     (clk),
      .reset   (reset),
      .load_i  (rd_load),
      .data_i  (bus_rdata),
      .ready_i (rd_ready),
      .valid_o (rd_valid_w),
      .data_o  (rd_data)
   );

   assign rd_valid    = rd_valid_w;
   assign busy        = busy_q;
   assign done        = done_q;
   assign bus_request = bus_request_q;
   assign bus_address = bus_address_q;
   assign bus_wdata   = bus_wdata_q;
   assign bus_wmask   = bus_wmask_q;
`ifdef CPU_BUS_INITIATOR_TIMEOUT_EN
   assign error       = error_q;
`else
   assign error       = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_bus_initiator.sv
// ---------------------------------------------------------------------------
// tb_cpu_bus_initiator
// Directed bench for cpu_bus_initiator. A zero-wait RAM responder answers
// requests in the cycle it sees them; a scoreboard holds the expected bus
// requests and read words derived from the command (aligned base + 4*i with
// 32-bit wrap, data from a shadow memory), and one compare process checks
// every request, stream handshake and done pulse against it. Cycle numbers
// are relative to the cycle in which start is high (cycle 0).
// ---------------------------------------------------------------------------
module tb_cpu_bus_initiator;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        cmd_write = 1'b0;
   logic [31:0] cmd_address = '0;
   logic [15:0] cmd_length = '0;
   logic        busy, done, error;
   logic        wr_valid = 1'b0;
   logic        wr_ready;
   logic [31:0] wr_data = '0;
   logic        rd_valid;
   logic        rd_ready = 1'b0;
   logic [31:0] rd_data;
   logic        bus_request;
   logic [31:0] bus_address, bus_wdata;
   logic [3:0]  bus_wmask;
   logic        bus_ack = 1'b0;
   logic [31:0] bus_rdata = '0;

   cpu_bus_initiator #(.TIMEOUT_CYCLES(15)) dut (
      .clk(clk), .reset(reset), .start(start), .cmd_write(cmd_write),
      .cmd_address(cmd_address), .cmd_length(cmd_length),
      .busy(busy), .done(done), .error(error),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
      .bus_request(bus_request), .bus_address(bus_address),
      .bus_wdata(bus_wdata), .bus_wmask(bus_wmask),
      .bus_ack(bus_ack), .bus_rdata(bus_rdata)
   );

   initial forever #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  wmask;
      logic [31:0] wdata;
   } req_t;

   req_t        exp_req_q[$];
   logic [31:0] exp_rd_q[$];
   logic [31:0] wr_q[$];
   logic [31:0] req_log[$];
   logic [31:0] rd_log[$];
   logic [31:0] ram[logic [31:0]];
   logic [31:0] model_mem[logic [31:0]];

   int   n_checks = 0;
   int   n_pass = 0;
   int   cyc = 0;
   int   t0 = 0;
   int   done_rel = -1;
   int   done_cnt = 0;
   int   err_cnt = 0;
   int   busy_cycles = 0;
   bit   ack_en = 1'b1;
   bit   spurious_ack = 1'b0;
   bit   rd_ready_en = 1'b1;
   logic exp_error = 1'b0;

   initial forever @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   function automatic logic [31:0] ram_rd(input logic [31:0] a);
      return ram.exists(a) ? ram[a] : 32'h0;
   endfunction

   // Expected bus traffic for a burst, straight from the command.
   task automatic push_burst(input bit wr, input logic [31:0] base, input int len,
                             input logic [31:0] d0);
      req_t r;
      for (int i = 0; i < len; i++) begin
         r.addr  = (base & ~32'h3) + 32'(4 * i);
         r.wmask = wr ? 4'hF : 4'h0;
         r.wdata = wr ? d0 + 32'(i) : 32'h0;
         exp_req_q.push_back(r);
         if (wr) begin
            wr_q.push_back(r.wdata);
            model_mem[r.addr] = r.wdata;
         end else begin
            exp_rd_q.push_back(model_mem.exists(r.addr) ? model_mem[r.addr] : 32'h0);
         end
      end
   endtask

   task automatic do_cmd(input bit wr, input logic [31:0] a, input logic [15:0] len);
      @(negedge clk);
      start = 1'b1; cmd_write = wr; cmd_address = a; cmd_length = len;
      t0 = cyc; busy_cycles = 0;
      req_log.delete(); rd_log.delete();
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int max_cycles);
      int base_cnt;
      base_cnt = done_cnt;
      for (int i = 0; i < max_cycles && done_cnt == base_cnt; i++) begin
         @(negedge clk); #2;
      end
      check(name, 32'(done_cnt != base_cnt), 32'd1);
   endtask

   // Zero-wait RAM responder and stream drivers.
   initial forever begin
      @(negedge clk);
      bus_ack = (bus_request && ack_en) || spurious_ack;
      if (bus_request && ack_en) begin
         if (bus_wmask == 4'hF) ram[bus_address] = bus_wdata;
         bus_rdata = ram_rd(bus_address);
      end else begin
         bus_rdata = 32'hBAD0_BAD0;
      end
      wr_valid = (wr_q.size() > 0);
      wr_data  = (wr_q.size() > 0) ? wr_q[0] : 32'h0;
      rd_ready = rd_ready_en;
   end

   // Compare process.
   initial begin
      req_t e;
      logic prev_req, prev_ack_rd, prev_rd_valid;
      prev_req = 1'b0; prev_ack_rd = 1'b0; prev_rd_valid = 1'b0;
      forever begin
         @(negedge clk); #1;
         if (reset) begin
            prev_req = 1'b0; prev_ack_rd = 1'b0; prev_rd_valid = 1'b0;
         end else begin
            if (busy) busy_cycles++;
            if (bus_request) begin
               $display("[cyc %0d] request addr=%08h wmask=%h wdata=%08h",
                        cyc - t0, bus_address, bus_wmask, bus_wdata);
               req_log.push_back(bus_address);
               check("req_single_cycle", prev_req, 1'b0);
               if (exp_req_q.size() == 0) begin
                  check("unexpected_request", 1'b1, 1'b0);
               end else begin
                  e = exp_req_q.pop_front();
                  check("req_addr", bus_address, e.addr);
                  check("req_wmask", bus_wmask, e.wmask);
                  if (e.wmask == 4'hF) check("req_wdata", bus_wdata, e.wdata);
               end
            end
            if (wr_ready) begin
               check("wr_ready_needs_valid", wr_valid, 1'b1);
               if (wr_q.size() > 0) void'(wr_q.pop_front());
            end
            if (rd_valid && !prev_rd_valid) check("rd_valid_after_ack", prev_ack_rd, 1'b1);
            if (rd_valid && rd_ready) begin
               $display("[cyc %0d] read word %08h", cyc - t0, rd_data);
               rd_log.push_back(rd_data);
               if (exp_rd_q.size() == 0) check("unexpected_rd_word", 1'b1, 1'b0);
               else check("rd_data", rd_data, exp_rd_q.pop_front());
            end
            if (done) begin
               done_cnt++;
               done_rel = cyc - t0;
               if (error) err_cnt++;
               $display("[cyc %0d] done error=%0b", done_rel, error);
               check("error_with_done", error, exp_error);
               check("busy_low_at_done", busy, 1'b0);
            end else if (error) begin
               check("error_without_done", error, 1'b0);
            end
            prev_req      = bus_request;
            prev_ack_rd   = bus_ack && bus_request && (bus_wmask == 4'h0);
            prev_rd_valid = rd_valid;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int dn, rq;
      repeat (2) @(negedge clk);
      #2;
      check("rst_busy", busy, 0);          check("rst_done", done, 0);
      check("rst_error", error, 0);        check("rst_wr_ready", wr_ready, 0);
      check("rst_rd_valid", rd_valid, 0);  check("rst_bus_request", bus_request, 0);
      check("rst_bus_address", bus_address, 0);
      check("rst_bus_wdata", bus_wdata, 0);
      check("rst_bus_wmask", bus_wmask, 0);
      check("rst_rd_data", rd_data, 0);
      reset = 1'b0;

      // Write burst, zero-wait, data always available.
      push_burst(1'b1, 32'h100, 4, 32'hA0);
      do_cmd(1'b1, 32'h100, 16'd4);
      wait_done("t1_done_seen", 100);
      check("t1_done_cycle", done_rel, 10);
      check("t1_busy_cycles", busy_cycles, 9);
      check("t1_req_count", req_log.size(), 4);
      check("t1_ram_100", ram_rd(32'h100), 32'hA0);
      check("t1_ram_10c", ram_rd(32'h10C), 32'hA3);
      check("t1_wr_words_left", wr_q.size(), 0);

      // Read back with no backpressure.
      rd_ready_en = 1'b1;
      push_burst(1'b0, 32'h100, 4, 32'h0);
      do_cmd(1'b0, 32'h100, 16'd4);
      wait_done("t2_done_seen", 100);
      check("t2_done_cycle", done_rel, 10);
      check("t2_rd_word0", rd_log.size() > 0 ? rd_log[0] : 32'hX, 32'hA0);
      check("t2_rd_word3", rd_log.size() > 3 ? rd_log[3] : 32'hX, 32'hA3);
      check("t2_rd_words_left", exp_rd_q.size(), 0);

      // Read with the consumer stalled; a stray ack while stalled is ignored.
      rd_ready_en = 1'b0;
      push_burst(1'b0, 32'h100, 3, 32'h0);
      do_cmd(1'b0, 32'h100, 16'd3);
      repeat (19) @(negedge clk);
      #2;
      check("t3_stall_req_count", req_log.size(), 1);
      check("t3_stall_rd_valid", rd_valid, 1);
      check("t3_stall_rd_data", rd_data, 32'hA0);
      check("t3_stall_busy", busy, 1);
      spurious_ack = 1'b1;
      @(negedge clk); #2;
      spurious_ack = 1'b0;
      rd_ready_en = 1'b1;
      wait_done("t3_done_seen", 100);
      check("t3_req_count", req_log.size(), 3);
      check("t3_rd_count", rd_log.size(), 3);
      check("t3_rd_word2", rd_log.size() > 2 ? rd_log[2] : 32'hX, 32'hA2);
      check("t3_rd_words_left", exp_rd_q.size(), 0);

      // Zero-length command.
      do_cmd(1'b0, 32'h40, 16'd0);
      wait_done("t4_done_seen", 20);
      check("t4_done_cycle", done_rel, 2);
      check("t4_req_count", req_log.size(), 0);
      check("t4_busy_cycles", busy_cycles, 1);

      // Address wrap, plus a start pulse while busy that must be ignored.
      push_burst(1'b1, 32'hFFFF_FFFE, 2, 32'h55);
      do_cmd(1'b1, 32'hFFFF_FFFE, 16'd2);
      @(negedge clk);
      start = 1'b1; cmd_write = 1'b0; cmd_address = 32'h800; cmd_length = 16'd5;
      @(negedge clk);
      start = 1'b0;
      wait_done("t5_done_seen", 100);
      check("t5_done_cycle", done_rel, 6);
      check("t5_req_count", req_log.size(), 2);
      check("t5_req0_addr", req_log.size() > 0 ? req_log[0] : 32'hX, 32'hFFFF_FFFC);
      check("t5_req1_addr", req_log.size() > 1 ? req_log[1] : 32'hX, 32'h0000_0000);
      check("t5_ram_0", ram_rd(32'h0), 32'h56);
      repeat (4) @(negedge clk);
      #2;
      check("t5_no_second_burst", busy, 0);

      // Reset while waiting for an ack that never comes.
      ack_en = 1'b0;
      push_burst(1'b0, 32'h200, 4, 32'h0);
      do_cmd(1'b0, 32'h200, 16'd4);
      repeat (4) @(negedge clk);
      #2;
      check("t6_busy_before_reset", busy, 1);
      check("t6_addr_before_reset", bus_address, 32'h200);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk); #2;
      check("t6_busy", busy, 0);              check("t6_done", done, 0);
      check("t6_error", error, 0);            check("t6_rd_valid", rd_valid, 0);
      check("t6_bus_request", bus_request, 0);
      check("t6_bus_address", bus_address, 0);
      check("t6_bus_wmask", bus_wmask, 0);    check("t6_rd_data", rd_data, 0);
      reset = 1'b0;
      exp_req_q.delete(); exp_rd_q.delete();
      ack_en = 1'b1;
      dn = done_cnt; rq = req_log.size();
      repeat (6) @(negedge clk);
      #2;
      check("t6_no_done_after_reset", done_cnt, dn);
      check("t6_no_req_after_reset", req_log.size(), rq);

`ifdef CPU_BUS_INITIATOR_TIMEOUT_EN
      // Responder never acks: abort 15 cycles after the first request.
      ack_en = 1'b0;
      exp_error = 1'b1;
      push_burst(1'b0, 32'h300, 1, 32'h0);
      do_cmd(1'b0, 32'h300, 16'd2);
      wait_done("t7_done_seen", 100);
      check("t7_done_cycle", done_rel, 17);
      check("t7_error_count", err_cnt, 1);
      check("t7_req_count", req_log.size(), 1);
      exp_error = 1'b0;
      exp_req_q.delete(); exp_rd_q.delete();
      ack_en = 1'b1;
`else
      check("no_error_pulses", err_cnt, 0);
`endif

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
